serial_add_ctrl: RTL and testbench

- Bit-serial add sequencer built around the single-bit gate-level full adder (addbit).
- Accepts two WIDTH-bit operands plus carry-in and drives the external full adder LSB-first, one bit per step.
- Waits a programmable number of settle cycles per bit so the adder's gate and path delays resolve, then samples sum and carry-out.
- Returns the WIDTH-bit sum and final carry with a start/busy/done handshake; sits between the test/control logic and the adder instance.

---
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer that drives an external full adder LSB-first.
module serial_add_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             co_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d, sum_out_q, sum_out_d;
    logic             carry_q, carry_d, co_out_q, co_out_d;
    logic             fa_a_q, fa_a_d, fa_b_q, fa_b_d, fa_ci_q, fa_ci_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [WIDTH-1:0] sum_next;
    logic             last_bit;

    assign sum_next = {fa_sum, sum_sh_q[WIDTH-1:1]};
    assign last_bit = bit_cnt_q == BW'(WIDTH - 1);

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        sum_sh_d     = sum_sh_q;
        sum_out_d    = sum_out_q;
        carry_d      = carry_q;
        co_out_d     = co_out_q;
        fa_a_d       = fa_a_q;
        fa_b_d       = fa_b_q;
        fa_ci_d      = fa_ci_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d      = SETTLE;
                a_sh_d       = a_in;
                b_sh_d       = b_in;
                carry_d      = ci_in;
                bit_cnt_d    = '0;
                settle_cnt_d = '0;
                fa_a_d       = a_in[0];
                fa_b_d       = b_in[0];
                fa_ci_d      = ci_in;
            end
            SETTLE: begin
                state_d      = (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
                settle_cnt_d = (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) ? 4'd0 : settle_cnt_q + 4'd1;
            end
            SAMPLE: begin
                sum_sh_d  = sum_next;
                carry_d   = fa_co;
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
                // fa_* are preloaded with the next bit so they stay stable over its whole window
                if (last_bit) begin
                    state_d   = DONE;
                    sum_out_d = sum_next;
                    co_out_d  = fa_co;
                    fa_a_d    = 1'b0;
                    fa_b_d    = 1'b0;
                    fa_ci_d   = 1'b0;
                end else begin
                    state_d = SETTLE;
                    fa_a_d  = a_sh_q[1];
                    fa_b_d  = b_sh_q[1];
                    fa_ci_d = fa_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            sum_sh_q     <= '0;
            sum_out_q    <= '0;
            carry_q      <= 1'b0;
            co_out_q     <= 1'b0;
            fa_a_q       <= 1'b0;
            fa_b_q       <= 1'b0;
            fa_ci_q      <= 1'b0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            sum_sh_q     <= sum_sh_d;
            sum_out_q    <= sum_out_d;
            carry_q      <= carry_d;
            co_out_q     <= co_out_d;
            fa_a_q       <= fa_a_d;
            fa_b_q       <= fa_b_d;
            fa_ci_q      <= fa_ci_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign busy    = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done    = state_q == DONE;
    assign sum_out = sum_out_q;
    assign co_out  = co_out_q;
    assign fa_a    = fa_a_q;
    assign fa_b    = fa_b_q;
    assign fa_ci   = fa_ci_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors and multi-cycle sequences against a behavioural full adder.
module tb_serial_add_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic       start1 = 0, ci1 = 0, busy1, done1, co1, fa_a1, fa_b1, fa_ci1, fa_sum1, fa_co1;
    logic [7:0] a1 = 0, b1 = 0, sum1;
    logic       start2 = 0, ci2 = 0, busy2, done2, co2, fa_a2, fa_b2, fa_ci2, fa_sum2, fa_co2;
    logic [7:0] a2 = 0, b2 = 0, sum2;

    assign fa_sum1 = fa_a1 ^ fa_b1 ^ fa_ci1;
    assign fa_co1  = (fa_a1 & fa_b1) | (fa_ci1 & (fa_a1 ^ fa_b1));
    assign fa_sum2 = fa_a2 ^ fa_b2 ^ fa_ci2;
    assign fa_co2  = (fa_a2 & fa_b2) | (fa_ci2 & (fa_a2 ^ fa_b2));

    serial_add_ctrl #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .ci_in(ci1),
        .busy(busy1), .done(done1), .sum_out(sum1), .co_out(co1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_ci(fa_ci1), .fa_sum(fa_sum1), .fa_co(fa_co1));

    serial_add_ctrl #(.WIDTH(8), .SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2), .ci_in(ci2),
        .busy(busy2), .done(done2), .sum_out(sum2), .co_out(co2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_ci(fa_ci2), .fa_sum(fa_sum2), .fa_co(fa_co2));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        for (int g = 0; g < 4 && done1; g++) @(negedge clk);
        a1 = a; b1 = b; ci1 = ci; start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
    endtask

    // counts edges from the accept until done is seen; optionally pulses a stray start at edge 'inject'
    task automatic wait1(input int inject, output int cyc, output int sum_chg);
        logic [7:0] s0;
        s0 = sum1;
        cyc = -1;
        sum_chg = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (k == inject) begin
                start1 = 1; a1 = 8'h01; b1 = 8'h00; ci1 = 0;
            end else if (k == inject + 1) start1 = 0;
            if (done1) begin
                cyc = k;
                break;
            end
            if (sum1 !== s0) sum_chg++;
        end
    endtask

    initial begin
        int         cyc, chg, first, pulses;
        logic [23:0] sa, sb, sc, ea, eb, ec;
        logic [7:0] ra, rb;
        logic       rc, c;
        logic [8:0] exp9;
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_sum", sum1, 0);
        check("rst_co", co1, 0);
        check("rst_fa", {fa_a1, fa_b1, fa_ci1}, 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            drive1(vecs[i].a, vecs[i].b, vecs[i].ci);
            wait1(-5, cyc, chg);
            check($sformatf("vec%0d_sum", i), sum1, vecs[i].s);
            check($sformatf("vec%0d_co", i), co1, vecs[i].co);
            check($sformatf("vec%0d_latency", i), cyc, 16);
            check($sformatf("vec%0d_sum_stable", i), chg, 0);
        end

        drive1(8'h0F, 8'h01, 1'b0);
        wait1(5, cyc, chg);
        check("ignore_sum", sum1, 8'h10);
        check("ignore_co", co1, 0);
        check("ignore_latency", cyc, 16);
        check("done_fa_zero", {fa_a1, fa_b1, fa_ci1}, 0);

        start1 = 1; a1 = 8'h20; b1 = 8'h03; ci1 = 0;
        @(posedge clk);
        #1 check("start_in_done_ignored", busy1, 0);
        @(posedge clk);
        #1 check("start_after_done_accepted", busy1, 1);
        start1 = 0;
        wait1(-5, cyc, chg);
        check("after_done_sum", sum1, 8'h23);
        check("after_done_latency", cyc, 16);

        drive1(8'hFF, 8'h00, 1'b1);
        repeat (8) @(posedge clk);
        #1 check("midop_busy", busy1, 1);
        check("midop_fa", {fa_a1, fa_b1}, 2'b10);
        rst_n = 0;
        #1;
        check("async_rst_busy", busy1, 0);
        check("async_rst_sum", sum1, 0);
        check("async_rst_co", co1, 0);
        check("async_rst_fa", {fa_a1, fa_b1, fa_ci1}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 if (done1) pulses++;
        end
        check("no_done_after_rst", pulses, 0);
        check("idle_after_rst", busy1, 0);
        drive1(8'h80, 8'h80, 1'b0);
        wait1(-5, cyc, chg);
        check("post_rst_sum", sum1, 8'h00);
        check("post_rst_co", co1, 1);

        ea = '0; eb = '0; ec = '0; c = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                ea[3*i+j] = ((8'h12 >> i) & 8'h01) != 0;
                eb[3*i+j] = ((8'h34 >> i) & 8'h01) != 0;
                ec[3*i+j] = c;
            end
            c = ((((8'h12 >> i) & 8'h01) + ((8'h34 >> i) & 8'h01) + {7'd0, c}) >> 1) != 0;
        end
        @(negedge clk);
        a2 = 8'h12; b2 = 8'h34; ci2 = 0; start2 = 1;
        @(posedge clk);
        #1 start2 = 0;
        sa = '0; sb = '0; sc = '0; first = -1;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k < 24) begin
                sa[k] = fa_a2; sb[k] = fa_b2; sc[k] = fa_ci2;
            end
            if (done2) begin
                first = k;
                break;
            end
        end
        check("sc2_fa_a_seq", sa, ea);
        check("sc2_fa_b_seq", sb, eb);
        check("sc2_fa_ci_seq", sc, ec);
        check("sc2_latency", first, 24);
        check("sc2_sum", sum2, 8'h46);
        check("sc2_co", co2, 0);
        check("sc2_done_fa", {fa_a2, fa_b2, fa_ci2}, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            drive1(ra, rb, rc);
            wait1(-5, cyc, chg);
            check($sformatf("rand%0d_%0h_%0h_%0h", i, ra, rb, rc), {co1, sum1}, exp9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
